// File: rtl/cpu_pkg.sv
// Shared MEM-stage types: FSM state encoding, MEM/WB record and its bubble value.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  rd;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_data:   32'd0,
    alu_result: 32'd0,
    rd:         5'd0
  };

  localparam int CNT_W = 8;

  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory port between the MEM stage and data memory.
interface mem_access_unit_if;
  logic        Mem_Req;
  logic        Mem_We;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic        Mem_Ack;
  logic [31:0] Mem_RData;

  modport master (
    output Mem_Req, Mem_We, Mem_Addr, Mem_WData,
    input  Mem_Ack, Mem_RData
  );

  modport slave (
    input  Mem_Req, Mem_We, Mem_Addr, Mem_WData,
    output Mem_Ack, Mem_RData
  );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; bubble selects the all-zero record instead of wb_in.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    bubble,
  input  mem_wb_t wb_in,
  output mem_wb_t wb_q
);

  mem_wb_t wb_d;

  always_comb begin
    wb_d = bubble ? MEM_WB_BUBBLE : wb_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= MEM_WB_BUBBLE;
    end else begin
      wb_q <= wb_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: branch/jump redirect, stalling load/store over a
// req/ack data-memory port with timeout, and the MEM/WB register.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               RegWrite_In,
  input  logic               MemToReg_In,
  input  logic               Branch_In,
  input  logic               MemRead_In,
  input  logic               MemWrite_In,
  input  logic               Jump_In,
  input  logic [31:0]        JumpAddr_In,
  input  logic [31:0]        BranchAddr_In,
  input  logic [31:0]        ALUResult_In,
  input  logic [31:0]        ReadData2_In,
  input  logic               ALUZero_In,
  input  logic [4:0]         Rd_In,
  mem_access_unit_if.master  mem,
  output logic               Stall,
  output logic               PCSrc,
  output logic [31:0]        PCTarget,
  output logic               RegWrite_Out,
  output logic               MemToReg_Out,
  output logic [31:0]        MemData_Out,
  output logic [31:0]        ALUResult_Out,
  output logic [4:0]         Rd_Out,
  output logic               MisalignErr,
  output logic               TimeoutErr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  mau_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             mis_err_q, mis_err_d;
  logic             to_err_q, to_err_d;

  logic             mem_op;
  logic             aligned;
  logic             wb_bubble;
  mem_wb_t          wb_in;
  mem_wb_t          wb_q;

  assign mem_op   = MemRead_In | MemWrite_In;
  assign aligned  = word_aligned(ALUResult_In[1:0]);

  assign PCSrc    = Jump_In | (Branch_In & ALUZero_In);
  assign PCTarget = Jump_In ? JumpAddr_In : BranchAddr_In;

  // DONE never stalls, so the held instruction leaves EX/MEM and cannot re-issue.
  assign Stall    = (state_q == BUSY) || ((state_q == IDLE) && mem_op && aligned);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    mis_err_d = 1'b0;
    to_err_d  = 1'b0;
    wb_bubble = 1'b0;
    wb_in     = '{reg_write:  RegWrite_In,
                  mem_to_reg: MemToReg_In,
                  mem_data:   32'd0,
                  alu_result: ALUResult_In,
                  rd:         Rd_In};

    case (state_q)
      IDLE: begin
        if (mem_op && aligned) begin
          wb_bubble = 1'b1;
          req_d     = 1'b1;
          we_d      = MemWrite_In;
          addr_d    = ALUResult_In;
          wdata_d   = ReadData2_In;
          cnt_d     = '0;
          abort_d   = 1'b0;
          state_d   = BUSY;
        end else if (mem_op) begin
          wb_in.reg_write = 1'b0;
          mis_err_d       = 1'b1;
        end
      end
      BUSY: begin
        wb_bubble = 1'b1;
        // An ack on the last allowed cycle is checked first and so beats the timeout.
        if (mem.Mem_Ack) begin
          rdata_d = mem.Mem_RData;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d  = 32'd0;
          req_d    = 1'b0;
          cnt_d    = '0;
          abort_d  = 1'b1;
          to_err_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        wb_in.mem_data = rdata_q;
        if (abort_q) begin
          wb_in.reg_write = 1'b0;
        end
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      mis_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      mis_err_q <= mis_err_d;
      to_err_q  <= to_err_d;
    end
  end

  assign mem.Mem_Req   = req_q;
  assign mem.Mem_We    = we_q;
  assign mem.Mem_Addr  = addr_q;
  assign mem.Mem_WData = wdata_q;
  assign MisalignErr   = mis_err_q;
  assign TimeoutErr    = to_err_q;

  mem_wb_reg u_mem_wb_reg (
    .clk    (Clk),
    .rst_n  (Rst),
    .bubble (wb_bubble),
    .wb_in  (wb_in),
    .wb_q   (wb_q)
  );

  assign RegWrite_Out  = wb_q.reg_write;
  assign MemToReg_Out  = wb_q.mem_to_reg;
  assign MemData_Out   = wb_q.mem_data;
  assign ALUResult_Out = wb_q.alu_result;
  assign Rd_Out        = wb_q.rd;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases then random instructions
// scored against a per-instruction outcome model.
module tb_mem_access_unit;

  localparam int MAX_WAIT = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        RegWrite_In = 1'b0, MemToReg_In = 1'b0, Branch_In = 1'b0;
  logic        MemRead_In = 1'b0, MemWrite_In = 1'b0, Jump_In = 1'b0;
  logic [31:0] JumpAddr_In = '0, BranchAddr_In = '0, ALUResult_In = '0, ReadData2_In = '0;
  logic        ALUZero_In = 1'b0;
  logic [4:0]  Rd_In = '0;
  logic        Stall, PCSrc;
  logic [31:0] PCTarget;
  logic        RegWrite_Out, MemToReg_Out;
  logic [31:0] MemData_Out, ALUResult_Out;
  logic [4:0]  Rd_Out;
  logic        MisalignErr, TimeoutErr;

  mem_access_unit_if mif ();

  mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .RegWrite_In   (RegWrite_In),
    .MemToReg_In   (MemToReg_In),
    .Branch_In     (Branch_In),
    .MemRead_In    (MemRead_In),
    .MemWrite_In   (MemWrite_In),
    .Jump_In       (Jump_In),
    .JumpAddr_In   (JumpAddr_In),
    .BranchAddr_In (BranchAddr_In),
    .ALUResult_In  (ALUResult_In),
    .ReadData2_In  (ReadData2_In),
    .ALUZero_In    (ALUZero_In),
    .Rd_In         (Rd_In),
    .mem           (mif.master),
    .Stall         (Stall),
    .PCSrc         (PCSrc),
    .PCTarget      (PCTarget),
    .RegWrite_Out  (RegWrite_Out),
    .MemToReg_Out  (MemToReg_Out),
    .MemData_Out   (MemData_Out),
    .ALUResult_Out (ALUResult_Out),
    .Rd_Out        (Rd_Out),
    .MisalignErr   (MisalignErr),
    .TimeoutErr    (TimeoutErr)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RegWrite_In = 1'b0; MemToReg_In = 1'b0; Branch_In = 1'b0;
    MemRead_In = 1'b0; MemWrite_In = 1'b0; Jump_In = 1'b0;
    JumpAddr_In = '0; BranchAddr_In = '0; ALUResult_In = '0; ReadData2_In = '0;
    ALUZero_In = 1'b0; Rd_In = '0;
  endtask

  // Called just after a rising edge; presents one instruction, plays memory with
  // ack on request cycle index k (k >= MAX_WAIT means never), and scores the outcome.
  task automatic run_instr(input string nm, input logic rw, input logic m2r, input logic br,
                           input logic mr, input logic mw, input logic jp, input logic zero,
                           input logic [31:0] ja, input logic [31:0] ba, input logic [31:0] alu,
                           input logic [31:0] rd2, input logic [4:0] rd, input int k,
                           input logic [31:0] rdata);
    logic        is_mem, is_aligned, exp_to, exp_mis, exp_rw, exp_pcsrc, to_done;
    logic [31:0] exp_data, exp_tgt;
    int          exp_stall, exp_req, nst, nreq, nmis, nto, c;
    bit          done;

    is_mem     = mr | mw;
    is_aligned = (alu[1:0] == 2'b00);
    exp_pcsrc  = jp | (br & zero);
    exp_tgt    = jp ? ja : ba;
    exp_stall  = 0; exp_req = 0; exp_rw = rw; exp_data = '0; exp_mis = 1'b0; exp_to = 1'b0;
    if (is_mem && !is_aligned) begin
      exp_rw = 1'b0; exp_mis = 1'b1;
    end else if (is_mem && k < MAX_WAIT) begin
      exp_stall = k + 2; exp_req = k + 1; exp_data = rdata;
    end else if (is_mem) begin
      exp_stall = MAX_WAIT + 1; exp_req = MAX_WAIT; exp_rw = 1'b0; exp_to = 1'b1;
    end

    RegWrite_In = rw; MemToReg_In = m2r; Branch_In = br; MemRead_In = mr;
    MemWrite_In = mw; Jump_In = jp; JumpAddr_In = ja; BranchAddr_In = ba;
    ALUResult_In = alu; ReadData2_In = rd2; ALUZero_In = zero; Rd_In = rd;

    nst = 0; nreq = 0; nmis = 0; nto = 0; c = 0; done = 0; to_done = 1'b0;
    while (!done && c < 40) begin
      @(negedge Clk);
      if (c == 0) begin
        chk({nm, ".pcsrc"}, {31'd0, PCSrc}, {31'd0, exp_pcsrc});
        chk({nm, ".pctarget"}, PCTarget, exp_tgt);
      end
      if (mif.Mem_Req) begin
        chk({nm, ".addr"}, mif.Mem_Addr, alu);
        chk({nm, ".we"}, {31'd0, mif.Mem_We}, {31'd0, mw});
        chk({nm, ".wdata"}, mif.Mem_WData, rd2);
        mif.Mem_Ack   = (nreq == k);
        mif.Mem_RData = (nreq == k) ? rdata : $urandom;
        nreq++;
      end else begin
        mif.Mem_Ack   = 1'($urandom_range(0, 1));
        mif.Mem_RData = $urandom;
      end
      if (Stall) nst++;
      nmis += int'(MisalignErr);
      nto  += int'(TimeoutErr);
      if (!Stall) begin
        done    = 1;
        to_done = TimeoutErr;
      end
      @(posedge Clk);
      #1;
      mif.Mem_Ack = 1'b0;
      c++;
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL %s.bound observed=stall_stuck expected=release_within_40", nm);
    end

    clear_inputs();
    @(negedge Clk);
    nmis += int'(MisalignErr);
    nto  += int'(TimeoutErr);
    chk({nm, ".stall_cycles"}, exp_stall, nst);
    chk({nm, ".req_cycles"}, nreq, exp_req);
    chk({nm, ".misalign_last"}, {31'd0, MisalignErr}, {31'd0, exp_mis});
    chk({nm, ".misalign_pulses"}, nmis, {31'd0, exp_mis});
    chk({nm, ".timeout_done"}, {31'd0, to_done}, {31'd0, exp_to});
    chk({nm, ".timeout_pulses"}, nto, {31'd0, exp_to});
    chk({nm, ".regwrite"}, {31'd0, RegWrite_Out}, {31'd0, exp_rw});
    chk({nm, ".memtoreg"}, {31'd0, MemToReg_Out}, {31'd0, m2r});
    chk({nm, ".memdata"}, MemData_Out, exp_data);
    chk({nm, ".aluresult"}, ALUResult_Out, alu);
    chk({nm, ".rd"}, {27'd0, Rd_Out}, {27'd0, rd});
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    mif.Mem_Ack   = 1'b0;
    mif.Mem_RData = '0;
    clear_inputs();

    repeat (2) @(posedge Clk);
    #1;
    chk("rst.req", {31'd0, mif.Mem_Req}, 32'd0);
    chk("rst.we", {31'd0, mif.Mem_We}, 32'd0);
    chk("rst.addr", mif.Mem_Addr, 32'd0);
    chk("rst.wdata", mif.Mem_WData, 32'd0);
    chk("rst.regwrite", {31'd0, RegWrite_Out}, 32'd0);
    chk("rst.memdata", MemData_Out, 32'd0);
    chk("rst.aluresult", ALUResult_Out, 32'd0);
    chk("rst.errs", {30'd0, MisalignErr, TimeoutErr}, 32'd0);
    chk("rst.stall", {31'd0, Stall}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;

    run_instr("add",     1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h10, 32'h0, 5'd5, 0, 32'h0);
    run_instr("lw40",    1, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h40, 32'h0, 5'd8, 2, 32'hDEADBEEF);
    run_instr("sw44",    0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h44, 32'h1234, 5'd0, 1, 32'h55);
    run_instr("sw44_k0", 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h44, 32'h1234, 5'd0, 0, 32'h66);
    run_instr("lw42",    1, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h42, 32'h0, 5'd9, 0, 32'h77);
    run_instr("lw_to",   1, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h80, 32'h0, 5'd3, 100, 32'h88);
    run_instr("lw_last", 1, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h84, 32'h0, 5'd4, MAX_WAIT - 1, 32'hCAFEF00D);
    run_instr("beq",     0, 0, 1, 0, 0, 0, 1, 32'h300, 32'h200, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    run_instr("beq_jmp", 0, 0, 1, 0, 0, 1, 1, 32'h300, 32'h200, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    run_instr("beq_nz",  0, 0, 1, 0, 0, 0, 0, 32'h300, 32'h200, 32'h0, 32'h0, 5'd0, 0, 32'h0);

    // Reset while an access is outstanding.
    MemRead_In = 1'b1; RegWrite_In = 1'b1; ALUResult_In = 32'h100; Rd_In = 5'd7;
    @(negedge Clk);
    chk("rstbusy.stall0", {31'd0, Stall}, 32'd1);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("rstbusy.req_before", {31'd0, mif.Mem_Req}, 32'd1);
    #2 Rst = 1'b0;
    #1;
    chk("rstbusy.req_dropped", {31'd0, mif.Mem_Req}, 32'd0);
    clear_inputs();
    #1;
    chk("rstbusy.stall_idle", {31'd0, Stall}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("rstbusy.req_after", {31'd0, mif.Mem_Req}, 32'd0);
    chk("rstbusy.stall_after", {31'd0, Stall}, 32'd0);
    @(posedge Clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       ra[1:0] = 2'($urandom_range(1, 3));
        default: ra[1:0] = 2'b00;
      endcase
      run_instr($sformatf("rnd%0d", i),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom, $urandom, ra, $urandom,
                5'($urandom_range(0, 31)), int'($urandom_range(0, MAX_WAIT + 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
